tt_vpu_ovi_load_buffer: RTL and testbench

- Load-return stage on the Open Vector Interface side of the vector unit.
- Accepts 512-bit OVI load-data beats from the core and splits each beat into VLEN-wide chunks.
- Pairs each chunk, in order, with the request IDs issued by vfp_pipeline and drives vfp_pipeline's i_rd_data_*_0 response port.
- Returns beat credits to the core, reports load completion for the memop sync handshake, and supports a kill-flush.

---
 rtl/tt_vpu_ovi_load_buffer.sv | 167 ++++++++++++++++
 tb/tb_tt_vpu_ovi_load_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_vpu_ovi_load_buffer.sv
// OVI load-return buffer: splits 512-bit load beats into VLEN chunks and pairs each
// chunk in order with the request IDs from vfp_pipeline. Also returns beat credits.
module tt_vpu_ovi_load_buffer #(
  parameter int VLEN       = 256,
  parameter int OVI_W      = 512,
  parameter int BEAT_DEPTH = 8,
  parameter int ID_DEPTH   = 8,
  parameter int ID_W       = 10
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_load_valid,
  input  logic [OVI_W-1:0]                i_load_data,
  input  logic [1:0]                      i_load_chunk_vld,
  output logic [$clog2(BEAT_DEPTH+1)-1:0] o_load_credit,
  input  logic                            i_data_req,
  input  logic                            i_mem_load,
  input  logic [ID_W-1:0]                 i_data_req_id,
  input  logic                            i_mem_last,
  output logic                            o_data_req_rtr,
  output logic                            o_rd_data_vld,
  output logic [ID_W-1:0]                 o_rd_data_resp_id,
  output logic [VLEN-1:0]                 o_rd_data,
  input  logic                            i_sync_start,
  input  logic                            i_sync_end,
  input  logic                            i_flush,
  output logic                            o_load_done,
  output logic                            o_overflow,
  output logic                            o_empty
);

  localparam int CD  = 2 * BEAT_DEPTH;
  localparam int CA  = $clog2(CD);
  localparam int CPW = CA + 1;
  localparam int IA  = $clog2(ID_DEPTH);
  localparam int IPW = IA + 1;
  localparam int CRW = $clog2(BEAT_DEPTH + 1);
  localparam int BCW = $clog2(CD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  logic [VLEN-1:0] c_data_mem [CD];
  logic            c_end_mem  [CD];
  logic [ID_W:0]   id_mem     [ID_DEPTH];

  logic [CPW-1:0] c_wr_q, c_wr_d, c_rd_q, c_rd_d;
  logic [IPW-1:0] i_wr_q, i_wr_d, i_rd_q, i_rd_d;
  logic [BCW-1:0] beats_q, beats_d;
  logic [CRW-1:0] credit_q, credit_d;
  logic           done_q, done_d;
  logic           overflow_q, overflow_d;
  state_t         state_q, state_d;

  logic [CPW-1:0] c_cnt, c_free, c_nwr;
  logic [CA-1:0]  c_idx0, c_idx1;
  logic           c_empty, i_empty, i_full;
  logic           two_chunks, accept, id_push, pop, head_end, head_last;

  assign c_cnt      = c_wr_q - c_rd_q;
  assign c_free     = CPW'(CD) - c_cnt;
  assign two_chunks = i_load_chunk_vld[1];
  assign c_nwr      = two_chunks ? CPW'(2) : CPW'(1);
  // Space is judged on the pre-pop occupancy so acceptance never depends on the response path.
  assign accept     = i_load_valid && (c_free >= c_nwr);
  assign c_idx0     = c_wr_q[CA-1:0];
  assign c_idx1     = c_idx0 + CA'(1);

  assign c_empty = (c_wr_q == c_rd_q);
  assign i_empty = (i_wr_q == i_rd_q);
  assign i_full  = (i_wr_q[IA] != i_rd_q[IA]) && (i_wr_q[IA-1:0] == i_rd_q[IA-1:0]);

  assign o_data_req_rtr = !i_full;
  assign id_push        = i_data_req && i_mem_load && !i_full;

  assign o_rd_data_vld     = !c_empty && !i_empty && !i_flush;
  assign pop               = o_rd_data_vld;
  assign o_rd_data         = c_data_mem[c_rd_q[CA-1:0]];
  assign head_end          = c_end_mem[c_rd_q[CA-1:0]];
  assign o_rd_data_resp_id = id_mem[i_rd_q[IA-1:0]][ID_W:1];
  assign head_last         = id_mem[i_rd_q[IA-1:0]][0];

  assign o_load_credit = credit_q;
  assign o_load_done   = done_q;
  assign o_overflow    = overflow_q;
  assign o_empty       = c_empty && i_empty;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      c_data_mem[c_idx0] <= i_load_data[VLEN-1:0];
      c_end_mem[c_idx0]  <= !two_chunks;
      if (two_chunks) begin
        c_data_mem[c_idx1] <= i_load_data[2*VLEN-1:VLEN];
        c_end_mem[c_idx1]  <= 1'b1;
      end
    end
    if (id_push) begin
      id_mem[i_wr_q[IA-1:0]] <= {i_data_req_id, i_mem_last};
    end
  end

  always_comb begin
    c_wr_d     = c_wr_q;
    c_rd_d     = c_rd_q;
    i_wr_d     = i_wr_q;
    i_rd_d     = i_rd_q;
    state_d    = state_q;
    done_d     = 1'b0;
    credit_d   = '0;
    overflow_d = overflow_q | (i_load_valid && !accept);
    beats_d    = beats_q + BCW'(accept) - BCW'(pop && head_end);

    if (accept)  c_wr_d = c_wr_q + c_nwr;
    if (id_push) i_wr_d = i_wr_q + IPW'(1);
    if (pop) begin
      c_rd_d = c_rd_q + CPW'(1);
      i_rd_d = i_rd_q + IPW'(1);
      if (head_end) credit_d = CRW'(1);
    end

    case (state_q)
      S_IDLE:   if (i_sync_start) state_d = S_ACTIVE;
      S_ACTIVE: if (pop && head_last) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:   if (i_sync_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A beat accepted in the flush cycle is discarded too, so its credit goes back now.
    if (i_flush) begin
      c_wr_d   = '0;
      c_rd_d   = '0;
      i_wr_d   = '0;
      i_rd_d   = '0;
      beats_d  = '0;
      credit_d = CRW'(beats_q + BCW'(accept));
      state_d  = S_IDLE;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      c_wr_q     <= '0;
      c_rd_q     <= '0;
      i_wr_q     <= '0;
      i_rd_q     <= '0;
      beats_q    <= '0;
      credit_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      c_wr_q     <= c_wr_d;
      c_rd_q     <= c_rd_d;
      i_wr_q     <= i_wr_d;
      i_rd_q     <= i_rd_d;
      beats_q    <= beats_d;
      credit_q   <= credit_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_tt_vpu_ovi_load_buffer.sv
// Bench for tt_vpu_ovi_load_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tt_vpu_ovi_load_buffer;

  logic         clk;
  logic         i_reset;
  logic         i_load_valid;
  logic [511:0] i_load_data;
  logic [1:0]   i_load_chunk_vld;
  logic [3:0]   o_load_credit;
  logic         i_data_req, i_mem_load, i_mem_last;
  logic [9:0]   i_data_req_id;
  logic         o_data_req_rtr, o_rd_data_vld;
  logic [9:0]   o_rd_data_resp_id;
  logic [255:0] o_rd_data;
  logic         i_sync_start, i_sync_end, i_flush;
  logic         o_load_done, o_overflow, o_empty;

  tt_vpu_ovi_load_buffer dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_chunk_vld(i_load_chunk_vld),
    .o_load_credit(o_load_credit),
    .i_data_req(i_data_req), .i_mem_load(i_mem_load), .i_data_req_id(i_data_req_id),
    .i_mem_last(i_mem_last), .o_data_req_rtr(o_data_req_rtr),
    .o_rd_data_vld(o_rd_data_vld), .o_rd_data_resp_id(o_rd_data_resp_id), .o_rd_data(o_rd_data),
    .i_sync_start(i_sync_start), .i_sync_end(i_sync_end), .i_flush(i_flush),
    .o_load_done(o_load_done), .o_overflow(o_overflow), .o_empty(o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void check(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: plain queues and a three-valued sync phase.
  typedef struct { logic [255:0] d; bit e; } chunk_t;
  typedef struct { logic [9:0] id; bit last; } rid_t;
  chunk_t cq[$];
  rid_t   iq[$];
  int     m_phase = 0;       // 0 idle, 1 waiting for last load, 2 completed
  int     m_credit = 0;
  bit     m_done = 1'b0;
  bit     m_ovf = 1'b0;
  bit     chk_en = 1'b0;

  int     sz, nw, held, ncredit, nphase;
  bit     ev, ndone;
  chunk_t ch;
  rid_t   rq;

  always @(negedge clk) begin
    if (chk_en) begin
      ev = (cq.size() > 0) && (iq.size() > 0) && !i_flush;
      check("rd_data_vld", o_rd_data_vld, ev);
      if (ev) begin
        check("resp_id", o_rd_data_resp_id, iq[0].id);
        check("rd_data", o_rd_data, cq[0].d);
      end
      check("data_req_rtr", o_data_req_rtr, iq.size() < 8);
      check("empty", o_empty, (cq.size() == 0) && (iq.size() == 0));
      check("load_credit", o_load_credit, m_credit);
      check("load_done", o_load_done, m_done);
      check("overflow", o_overflow, m_ovf);

      if (i_reset) begin
        cq.delete(); iq.delete();
        m_phase = 0; m_credit = 0; m_done = 0; m_ovf = 0;
      end else begin
        sz = cq.size();
        ncredit = 0; ndone = 0; nphase = m_phase;
        if (m_phase == 0 && i_sync_start) nphase = 1;
        if (m_phase == 2 && i_sync_end) nphase = 0;
        if (ev) begin
          ch = cq.pop_front();
          rq = iq.pop_front();
          if (ch.e) ncredit = 1;
          if (m_phase == 1 && rq.last) begin nphase = 2; ndone = 1; end
        end
        if (i_load_valid) begin
          nw = i_load_chunk_vld[1] ? 2 : 1;
          if (16 - sz >= nw) begin
            cq.push_back('{d: i_load_data[255:0], e: (nw == 1)});
            if (nw == 2) cq.push_back('{d: i_load_data[511:256], e: 1'b1});
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (i_data_req && i_mem_load && (iq.size() + (ev ? 1 : 0) < 8 + (ev ? 1 : 0))
            && (iq.size() + (ev ? 1 : 0)) < 8)
          iq.push_back('{id: i_data_req_id, last: i_mem_last});
        if (i_flush) begin
          held = 0;
          foreach (cq[k]) if (cq[k].e) held++;
          ncredit = held;
          cq.delete(); iq.delete();
          nphase = 0; ndone = 0;
        end
        m_credit = ncredit; m_done = ndone; m_phase = nphase;
      end
    end
  end

  int credit_sum = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    i_load_valid = 0; i_data_req = 0; i_mem_load = 0; i_mem_last = 0;
    i_sync_start = 0; i_sync_end = 0; i_flush = 0;
    #1;
    credit_sum += int'(o_load_credit);
  endtask

  task automatic beat(input logic [511:0] d, input logic [1:0] cv);
    i_load_valid = 1; i_load_data = d; i_load_chunk_vld = cv;
  endtask

  task automatic req(input logic [9:0] id, input logic last);
    i_data_req = 1; i_mem_load = 1; i_data_req_id = id; i_mem_last = last;
  endtask

  localparam logic [255:0] A_LO = 256'h0123456789abcdef_0011223344556677_8899aabbccddeeff_fedcba9876543210;
  localparam logic [255:0] A_HI = 256'hdeadbeefdeadbeef_cafef00dcafef00d_1111111111111111_2222222222222222;
  localparam logic [255:0] B_LO = 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888;
  localparam logic [255:0] B_HI = 256'h9999999999999999_aaaaaaaaaaaaaaaa_bbbbbbbbbbbbbbbb_cccccccccccccccc;

  initial begin
    i_reset = 1; i_load_valid = 0; i_load_data = '0; i_load_chunk_vld = 2'b01;
    i_data_req = 0; i_mem_load = 0; i_mem_last = 0; i_data_req_id = '0;
    i_sync_start = 0; i_sync_end = 0; i_flush = 0;

    tick(); chk_en = 1; tick(); tick();
    i_reset = 0; tick();
    check("reset_vld", o_rd_data_vld, 0);
    check("reset_rtr", o_data_req_rtr, 1);
    check("reset_empty", o_empty, 1);
    check("reset_credit", o_load_credit, 0);
    check("reset_overflow", o_overflow, 0);

    // single one-chunk load
    i_sync_start = 1; tick();
    req(10'd5, 1); tick();
    beat({A_HI, A_LO}, 2'b01); tick();
    check("single_vld", o_rd_data_vld, 1);
    check("single_id", o_rd_data_resp_id, 10'd5);
    check("single_data", o_rd_data, A_LO);
    tick();
    check("single_credit", o_load_credit, 1);
    check("single_done", o_load_done, 1);
    i_sync_end = 1; tick(); tick();

    // two-chunk beat
    i_sync_start = 1; tick();
    req(10'd1, 0); tick();
    req(10'd2, 1); tick();
    beat({B_HI, B_LO}, 2'b11); tick();
    check("two_id0", o_rd_data_resp_id, 10'd1);
    check("two_data0", o_rd_data, B_LO);
    tick();
    check("two_id1", o_rd_data_resp_id, 10'd2);
    check("two_data1", o_rd_data, B_HI);
    check("two_credit_early", o_load_credit, 0);
    tick();
    check("two_credit", o_load_credit, 1);
    check("two_done", o_load_done, 1);
    tick();
    check("two_done_once", o_load_done, 0);
    i_sync_end = 1; tick();

    // ID starvation
    beat({A_LO, B_LO}, 2'b01); tick();
    check("starve_vld", o_rd_data_vld, 0);
    tick(); tick(); tick();
    req(10'd3, 0); tick();
    check("starve_late_vld", o_rd_data_vld, 1);
    check("starve_late_id", o_rd_data_resp_id, 10'd3);
    tick();
    for (int i = 0; i < 9; i++) begin
      req(10'(20 + i), 0); tick();
      if (i == 7) check("starve_rtr_full", o_data_req_rtr, 0);
    end
    for (int i = 0; i < 4; i++) begin beat({B_HI, A_HI}, 2'b11); tick(); end
    for (int i = 0; i < 6; i++) tick();
    check("starve_drained", o_empty, 1);

    // fill and overflow
    for (int i = 0; i < 8; i++) begin beat({256'(i + 100), 256'(i)}, 2'b11); tick(); end
    check("full_no_ovf", o_overflow, 0);
    beat({B_HI, B_LO}, 2'b11); tick();
    check("overflow_set", o_overflow, 1);
    credit_sum = 0;
    for (int i = 0; i < 16; i++) begin req(10'(40 + i), 0); tick(); end
    tick(); tick();
    check("full_credits", credit_sum, 8);
    i_reset = 1; tick(); i_reset = 0; tick();
    check("rst_overflow_clr", o_overflow, 0);

    // flush
    i_sync_start = 1; tick();
    for (int i = 0; i < 3; i++) begin beat({A_HI, 256'(i)}, 2'b11); tick(); end
    req(10'd7, 0); tick(); tick();
    i_flush = 1; tick();
    check("flush_credit", o_load_credit, 3);
    check("flush_empty", o_empty, 1);
    check("flush_no_done", o_load_done, 0);
    req(10'd8, 1); beat({A_HI, A_LO}, 2'b01); tick(); tick();
    check("flush_idle_no_done", o_load_done, 0);
    tick(); tick();

    // 40-beat stream through pointer wrap
    i_sync_start = 1; tick();
    credit_sum = 0;
    for (int i = 0; i < 40; i++) begin
      beat({256'(i), 256'(i)}, 2'b01); req(10'(i), i == 39); tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("stream_credits", credit_sum, 40);
    check("stream_no_ovf", o_overflow, 0);
    check("stream_empty", o_empty, 1);
    i_sync_end = 1; tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        beat(d, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01);
      end
      if ($urandom_range(0, 1) == 1) begin
        i_data_req = 1; i_mem_load = ($urandom_range(0, 3) != 0);
        i_data_req_id = 10'($urandom); i_mem_last = ($urandom_range(0, 7) == 0);
      end
      i_sync_start = ($urandom_range(0, 15) == 0);
      i_sync_end   = ($urandom_range(0, 15) == 0);
      i_flush      = ($urandom_range(0, 63) == 0);
      i_reset      = ($urandom_range(0, 499) == 0);
      tick();
    end
    i_reset = 0; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
